// File: rtl/proc_sequencer_if.sv
// Host/proc handshake bundle for proc_sequencer: enqueue port, control inputs, Run/DIN/Done issue link and status.
interface proc_sequencer_if #(
    parameter int N  = 8,
    parameter int AW = 3
);
    logic          push;
    logic [N-1:0]  push_instr;
    logic [N-1:0]  push_imm;
    logic          halt;
    logic          flush;
    logic          done;
    logic          run;
    logic [N-1:0]  din;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          busy;
    logic [15:0]   retired;
    logic          err;

    modport master (
        output push, push_instr, push_imm, halt, flush, done,
        input  run, din, full, empty, count, busy, retired, err
    );

    modport slave (
        input  push, push_instr, push_imm, halt, flush, done,
        output run, din, full, empty, count, busy, retired, err
    );
endinterface

// File: rtl/proc_sequencer.sv
// Instruction FIFO and Run/DIN issue controller for the 8-register proc datapath.
// Optional WAIT-state watchdog is built only when SEQ_WATCHDOG_EN is defined.
module proc_sequencer #(
    parameter int N     = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int TMO   = 15
) (
    input  logic              clk,
    input  logic              rst,
    proc_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    instr_mem [DEPTH];
    logic [N-1:0]    imm_mem   [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            run_q, run_d;
    logic [N-1:0]    din_q, din_d;
    logic            busy_q, busy_d;
    logic [15:0]     retired_q, retired_d;
    logic            err_q, err_d;
    logic            cur_mvi_q, cur_mvi_d;
    logic [N-1:0]    cur_imm_q, cur_imm_d;
    logic            push_acc;
    logic            pop;
    logic            do_flush;
    logic            wd_fire;
    logic [N-1:0]    head_instr;

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TMO + 1);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
        err_d     = err_q;
        cur_mvi_d = cur_mvi_q;
        cur_imm_d = cur_imm_q;
        wd_fire   = 1'b0;

`ifdef SEQ_WATCHDOG_EN
        wd_d = '0;
        if (state_q == WAIT && !bus.done) begin
            if (wd_q == WD_W'(TMO - 1)) begin
                wd_fire = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif

        // A watchdog timeout empties the queue exactly like a host flush.
        do_flush = bus.flush || wd_fire;
        push_acc = bus.push && !full_q && !do_flush;
        pop      = (state_q == ISSUE);

        wr_ptr_d = wr_ptr_q + AW'(push_acc);
        if (do_flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + AW'(pop);
            count_d  = count_q + (AW+1)'(push_acc) - (AW+1)'(pop);
        end

        case (state_q)
            IDLE: begin
                if (!empty_q && !bus.halt && !bus.flush && !err_q) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d   = WAIT;
                cur_mvi_d = (instr_mem[rd_ptr_q][N-1:N-2] == 2'b01);
                cur_imm_d = imm_mem[rd_ptr_q];
            end
            WAIT: begin
                if (bus.done) begin
                    retired_d = retired_q + 16'd1;
                    state_d   = (count_d != '0 && !bus.halt && !err_q) ? ISSUE : IDLE;
                end else if (wd_fire) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // An entry written this cycle into an empty queue must bypass the memory for back-to-back issue.
        if (push_acc && rd_ptr_d == wr_ptr_q) begin
            head_instr = bus.push_instr;
        end else begin
            head_instr = instr_mem[rd_ptr_d];
        end

        run_d = (state_d == ISSUE);
        if (state_d == ISSUE) begin
            din_d = head_instr;
        end else if (state_d == WAIT && cur_mvi_d) begin
            din_d = cur_imm_d;
        end else begin
            din_d = '0;
        end

        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            instr_mem[wr_ptr_q] <= bus.push_instr;
            imm_mem[wr_ptr_q]   <= bus.push_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            run_q     <= 1'b0;
            din_q     <= '0;
            busy_q    <= 1'b0;
            retired_q <= '0;
            err_q     <= 1'b0;
            cur_mvi_q <= 1'b0;
            cur_imm_q <= '0;
`ifdef SEQ_WATCHDOG_EN
            wd_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            run_q     <= run_d;
            din_q     <= din_d;
            busy_q    <= busy_d;
            retired_q <= retired_d;
            err_q     <= err_d;
            cur_mvi_q <= cur_mvi_d;
            cur_imm_q <= cur_imm_d;
`ifdef SEQ_WATCHDOG_EN
            wd_q      <= wd_d;
`endif
        end
    end

    assign bus.run     = run_q;
    assign bus.din     = din_q;
    assign bus.full    = full_q;
    assign bus.empty   = empty_q;
    assign bus.count   = count_q;
    assign bus.busy    = busy_q;
    assign bus.retired = retired_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_proc_sequencer.sv
// Bench for proc_sequencer: behavioural proc model plus an issue scoreboard on Run/DIN.
// Watchdog expectations follow SEQ_WATCHDOG_EN.
module tb_proc_sequencer;
    localparam int N  = 8;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    proc_sequencer_if #(.N(N), .AW(AW)) bus ();

    proc_sequencer #(.N(N), .DEPTH(8), .AW(AW), .TMO(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          tests = 0;
    int          fails = 0;
    int          runs  = 0;
    int          b2b   = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  mon_exp;
    logic [7:0]  regs [8];
    logic [7:0]  ir;
    int          pending = 0;
    bit          stall = 1'b0;

    task automatic execute(input logic [7:0] i, input logic [7:0] d);
        case (i[7:6])
            2'b00:   regs[i[5:3]] = regs[i[2:0]];
            2'b01:   regs[i[5:3]] = d;
            2'b10:   regs[i[5:3]] = regs[i[5:3]] + regs[i[2:0]];
            default: regs[i[5:3]] = regs[i[5:3]] - regs[i[2:0]];
        endcase
    endtask

    // Scoreboard monitor first, then the proc model raises Done per opcode latency.
    always @(negedge clk) begin : monitor_and_model
        if (bus.run === 1'b1) begin
            runs++;
            if (bus.done === 1'b1) b2b++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL unexpected_run: got din=0x%0h, expected no Run", bus.din);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.din !== mon_exp) begin
                    fails++;
                    $display("[TB] FAIL issue_din: got 0x%0h, expected 0x%0h", bus.din, mon_exp);
                end
            end
        end
        bus.done = 1'b0;
        if (pending > 0) begin
            pending--;
            if (pending == 0) begin
                bus.done = 1'b1;
                execute(ir, bus.din);
            end
        end
        if (bus.run === 1'b1) begin
            ir = bus.din;
            if (!stall) pending = ir[7] ? 3 : 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] instr, input logic [7:0] imm, input bit accept);
        @(negedge clk);
        bus.push       = 1'b1;
        bus.push_instr = instr;
        bus.push_imm   = imm;
        if (accept) exp_q.push_back(instr);
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.empty === 1'b1 && bus.busy === 1'b0) && n < max_cycles);
        check_output(name, 32'(bus.empty === 1'b1 && bus.busy === 1'b0), 32'd1);
    endtask

    initial begin : global_timeout
        #2000000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        rst            = 1'b1;
        bus.push       = 1'b0;
        bus.push_instr = '0;
        bus.push_imm   = '0;
        bus.halt       = 1'b0;
        bus.flush      = 1'b0;
        repeat (2) @(negedge clk);
        check_output("rst_run",     32'(bus.run),     32'd0);
        check_output("rst_din",     32'(bus.din),     32'd0);
        check_output("rst_count",   32'(bus.count),   32'd0);
        check_output("rst_empty",   32'(bus.empty),   32'd1);
        check_output("rst_full",    32'(bus.full),    32'd0);
        check_output("rst_busy",    32'(bus.busy),    32'd0);
        check_output("rst_retired", 32'(bus.retired), 32'd0);
        check_output("rst_err",     32'(bus.err),     32'd0);
        rst = 1'b0;

        // Fill while halted so the queue reaches full; the ninth push must be dropped.
        bus.halt = 1'b1;
        for (int i = 0; i < 9; i++) apply_stimulus(8'h40 | 8'(i << 3), 8'(8 - i), i < 8);
        @(negedge clk);
        bus.push = 1'b0;
        check_output("t1_full",  32'(bus.full),  32'd1);
        check_output("t1_count", 32'(bus.count), 32'd8);
        check_output("t1_busy",  32'(bus.busy),  32'd0);
        bus.halt = 1'b0;
        wait_idle(200, "t1_drain");
        check_output("t1_retired", 32'(bus.retired), 32'd8);
        check_output("t1_runs",    32'(runs),        32'd8);
        check_output("t1_b2b",     32'(b2b),         32'd7);
        for (int i = 0; i < 8; i++) check_output($sformatf("t1_r%0d", i), 32'(regs[i]), 32'(8 - i));

        apply_stimulus(8'h81, 8'h00, 1'b1);
        @(negedge clk);
        bus.push = 1'b0;
        wait_idle(50, "t2_drain");
        check_output("t2_r0",      32'(regs[0]),     32'd15);
        check_output("t2_retired", 32'(bus.retired), 32'd9);
        check_output("t2_runs",    32'(runs),        32'd9);

        apply_stimulus(8'h13, 8'h00, 1'b1);
        apply_stimulus(8'hC1, 8'h00, 1'b1);
        @(negedge clk);
        bus.push = 1'b0;
        wait_idle(50, "t3_drain");
        check_output("t3_b2b",     32'(b2b),         32'd8);
        check_output("t3_r2",      32'(regs[2]),     32'd5);
        check_output("t3_r0",      32'(regs[0]),     32'd8);
        check_output("t3_retired", 32'(bus.retired), 32'd11);

        for (int i = 0; i < 3; i++) apply_stimulus(8'hBF, 8'h00, 1'b1);
        @(negedge clk);
        bus.push = 1'b0;
        bus.halt = 1'b1;
        repeat (10) @(negedge clk);
        check_output("t4_count",   32'(bus.count),   32'd2);
        check_output("t4_busy",    32'(bus.busy),    32'd0);
        check_output("t4_retired", 32'(bus.retired), 32'd12);
        check_output("t4_runs",    32'(runs),        32'd12);
        bus.halt = 1'b0;
        wait_idle(50, "t4_drain");
        check_output("t4_retired_all", 32'(bus.retired), 32'd14);
        check_output("t4_r7",          32'(regs[7]),     32'd8);
        check_output("t4_runs_all",    32'(runs),        32'd14);

        // Flush lands mid-WAIT together with a push that must also be discarded.
        for (int i = 0; i < 4; i++) apply_stimulus(8'hB6, 8'h00, 1'b1);
        @(negedge clk);
        bus.push_instr = 8'h00;
        bus.flush      = 1'b1;
        exp_q.delete();
        @(negedge clk);
        bus.push  = 1'b0;
        bus.flush = 1'b0;
        repeat (10) @(negedge clk);
        check_output("t5_count",   32'(bus.count),   32'd0);
        check_output("t5_empty",   32'(bus.empty),   32'd1);
        check_output("t5_busy",    32'(bus.busy),    32'd0);
        check_output("t5_retired", 32'(bus.retired), 32'd15);
        check_output("t5_runs",    32'(runs),        32'd15);
        check_output("t5_r6",      32'(regs[6]),     32'd4);

        stall = 1'b1;
        apply_stimulus(8'h00, 8'h00, 1'b1);
        apply_stimulus(8'h00, 8'h00, 1'b1);
        @(negedge clk);
        bus.push = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        n = 0;
        while (bus.err !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        exp_q.delete();
        check_output("t6_err",   32'(bus.err),   32'd1);
        check_output("t6_busy",  32'(bus.busy),  32'd0);
        check_output("t6_empty", 32'(bus.empty), 32'd1);
        repeat (5) @(negedge clk);
        check_output("t6_err_sticky", 32'(bus.err), 32'd1);
        check_output("t6_runs",       32'(runs),    32'd16);
`else
        n = 0;
        repeat (40) @(negedge clk);
        check_output("t6_err",   32'(bus.err),   32'd0);
        check_output("t6_busy",  32'(bus.busy),  32'd1);
        check_output("t6_count", 32'(bus.count), 32'd1);
        check_output("t6_runs",  32'(runs),      32'd16);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
